// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional add mode is enabled by defining SERIAL_SUBTRACTOR_ADD_MODE_EN.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_N = 4;

    // Smallest r with 2**r >= n; counter width for N shift cycles (0..N-1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// Combinational 1-bit subtract cell (x - y - bin).
// With SERIAL_SUBTRACTOR_ADD_MODE_EN, op=1 turns it into a full adder (bin acts as carry).
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic op,
`endif
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        if (op) begin
            bout = (x & y) | ((x ^ y) & bin);
        end
`endif
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: a - b, LSB first, start/done handshake, N+1 cycles per result.
// Defining SERIAL_SUBTRACTOR_ADD_MODE_EN adds an 'op' port (0 = subtract, 1 = add).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    input  logic         op,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         overflow
);

    localparam int unsigned CW = clog2(N);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   res_q, res_d;
    logic           bw_q, bw_d;
    logic [N-1:0]   diff_q, diff_d;
    logic           bo_q, bo_d;
    logic           ov_q, ov_d;
    logic           op_q, op_d;

    logic           accept;
    logic           last_bit;
    logic           cell_d;
    logic           cell_bout;
    logic           ov_bit;

    assign accept   = start && (state_q != SHIFT);
    assign last_bit = (cnt_q == CW'(N - 1));

    full_subtractor_cell u_cell (
        .x    (a_q[0]),
        .y    (b_q[0]),
        .bin  (bw_q),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        .op   (op_q),
`endif
        .d    (cell_d),
        .bout (cell_bout)
    );

    // On the last shift the cell sees the operand MSBs, so overflow needs no extra copies.
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    assign ov_bit = op_q ? ((a_q[0] == b_q[0]) && (cell_d != a_q[0]))
                         : ((a_q[0] != b_q[0]) && (cell_d != a_q[0]));
    assign op_d   = accept ? op : op_q;
`else
    assign ov_bit = (a_q[0] != b_q[0]) && (cell_d != a_q[0]);
    assign op_d   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state_q == SHIFT);
        done       = (state_q == DONE);
        diff       = diff_q;
        borrow_out = bo_q;
        overflow   = ov_q;
    end

    // Datapath next-state
    always_comb begin
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        bw_d   = bw_q;
        diff_d = diff_q;
        bo_d   = bo_q;
        ov_d   = ov_q;
        if (accept) begin
            a_d   = a;
            b_d   = b;
            cnt_d = '0;
            bw_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {cell_d, res_q[N-1:1]};
            bw_d  = cell_bout;
            cnt_d = cnt_q + 1'b1;
            if (last_bit) begin
                diff_d = {cell_d, res_q[N-1:1]};
                bo_d   = cell_bout;
                ov_d   = ov_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            bw_q   <= 1'b0;
            diff_q <= '0;
            bo_q   <= 1'b0;
            ov_q   <= 1'b0;
            op_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            bw_q   <= bw_d;
            diff_q <= diff_d;
            bo_q   <= bo_d;
            ov_q   <= ov_d;
            op_q   <= op_d;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (N=4): vector table plus handshake/reset sequences.
module tb_serial_subtractor;

    localparam int unsigned N = 4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] diff;
        logic       bo;
        logic       ov;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       busy, done, borrow_out, overflow;
    logic [3:0] diff;

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
        .op         (1'b0),
`endif
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Issue one operation; returns cycles from accept edge to done and busy cycle count.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                          output int lat, output int bcnt);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t vecs[10];
    int   lat, bcnt, gap, seen;

    initial begin
        vecs[0] = '{4'h7, 4'h3, 4'h4, 1'b0, 1'b0};
        vecs[1] = '{4'h3, 4'h4, 4'hF, 1'b1, 1'b0};
        vecs[2] = '{4'h8, 4'h1, 4'h7, 1'b0, 1'b1};
        vecs[3] = '{4'h7, 4'hF, 4'h8, 1'b1, 1'b1};
        vecs[4] = '{4'h5, 4'h5, 4'h0, 1'b0, 1'b0};
        vecs[5] = '{4'hA, 4'h0, 4'hA, 1'b0, 1'b0};
        vecs[6] = '{4'h0, 4'h1, 4'hF, 1'b1, 1'b0};
        vecs[7] = '{4'h8, 4'h7, 4'h1, 1'b0, 1'b1};
        vecs[8] = '{4'hC, 4'h6, 4'h6, 1'b0, 1'b1};
        vecs[9] = '{4'h2, 4'hE, 4'h4, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {28'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow_out}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, bcnt);
            check($sformatf("v%0d_latency", i), lat, 32'd5);
            check($sformatf("v%0d_busy_cycles", i), bcnt, 32'd4);
            check($sformatf("v%0d_diff", i), {28'd0, diff}, {28'd0, vecs[i].diff});
            check($sformatf("v%0d_borrow", i), {31'd0, borrow_out}, {31'd0, vecs[i].bo});
            check($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vecs[i].ov});
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // start during SHIFT is ignored
        @(negedge clk);
        a = 4'h9; b = 4'h2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'h1; b = 4'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int i = 3; i <= 20; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        check("busy_start_latency", lat, 32'd5);
        check("busy_start_diff", {28'd0, diff}, 32'h7);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) seen++;
            check("hold_diff", {28'd0, diff}, 32'h7);
        end
        check("busy_start_single_done", seen, 32'd0);

        // Back-to-back: start held through DONE
        @(negedge clk);
        a = 4'h7; b = 4'h3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 4'h0; b = 4'h1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        check("b2b_first_latency", lat, 32'd5);
        check("b2b_first_diff", {28'd0, diff}, 32'h4);
        @(negedge clk);
        start = 1'b0;
        check("b2b_reaccept_busy", {31'd0, busy}, 32'd1);
        gap = 0;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                gap = i;
                break;
            end
            @(negedge clk);
        end
        check("b2b_gap", gap, 32'd5);
        check("b2b_second_diff", {28'd0, diff}, 32'hF);
        check("b2b_second_borrow", {31'd0, borrow_out}, 32'd1);

        // Reset in 2nd SHIFT cycle
        @(negedge clk);
        a = 4'h9; b = 4'h2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_diff", {28'd0, diff}, 32'd0);
        check("mid_rst_borrow", {31'd0, borrow_out}, 32'd0);
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("mid_rst_no_done", seen, 32'd0);
        run_op(4'h6, 4'h2, lat, bcnt);
        check("post_rst_latency", lat, 32'd5);
        check("post_rst_diff", {28'd0, diff}, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
